// File: rtl/remap_pkg.sv
// Shared types for the remap engine.
//   mode_e  : remap mode carried on mode_i (ROW_TILED, COL_TILED, UNTILE, TRANSPOSE)
//   state_e : engine control states (IDLE, RUN, DRAIN, DONE)
package remap_pkg;

  typedef enum logic [1:0] {
    ROW_TILED = 2'd0,
    COL_TILED = 2'd1,
    UNTILE    = 2'd2,
    TRANSPOSE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/remap_engine_if.sv
// Signal bundle matching the remap_engine job-control and memory ports.
//   master : engine view (drives status and memory addresses/write side)
//   slave  : host/memory view (drives job request and source read data)
interface remap_engine_if #(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 8
);
  logic                     start;
  logic [1:0]               mode;
  logic [SizeAddrWidth-1:0] rows;
  logic [SizeAddrWidth-1:0] cols;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [AddrWidth-1:0]     src_addr;
  logic [DataWidth-1:0]     src_rdata;
  logic [AddrWidth-1:0]     dst_addr;
  logic [DataWidth-1:0]     dst_wdata;
  logic                     dst_we;

  modport master (
    input  start, mode, rows, cols, src_rdata,
    output busy, done, err, src_addr, dst_addr, dst_wdata, dst_we
  );

  modport slave (
    output start, mode, rows, cols, src_rdata,
    input  busy, done, err, src_addr, dst_addr, dst_wdata, dst_we
  );
endinterface

// File: rtl/remap_addr_gen.sv
// Incremental source/destination address generator for the remap engine.
// Walks (r,c) in row-major order using tile counters (j, Tc, i, Tr) and
// base registers; no per-element multiplication.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : latch mode/dimensions and point at element 0
//   adv_i         : step to the next element
//   mode_i        : remap mode latched on load_i
//   rows_i/cols_i : matrix dimensions latched on load_i (assumed valid)
//   src_addr_o    : source address of the current element
//   dst_addr_o    : destination address of the current element
//   last_o        : current element is the final one (r=R-1, c=C-1)
module remap_addr_gen
  import remap_pkg::*;
#(
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned TileSize      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     adv_i,
  input  mode_e                    mode_i,
  input  logic [SizeAddrWidth-1:0] rows_i,
  input  logic [SizeAddrWidth-1:0] cols_i,
  output logic [AddrWidth-1:0]     src_addr_o,
  output logic [AddrWidth-1:0]     dst_addr_o,
  output logic                     last_o
);

  localparam int unsigned TileLog2 = $clog2(TileSize);
  localparam int unsigned TileArea = TileSize * TileSize;

  typedef logic [AddrWidth-1:0]     addr_t;
  typedef logic [SizeAddrWidth-1:0] size_t;
  typedef logic [TileLog2-1:0]      sub_t;

  mode_e mode_q, mode_d;
  size_t tcols_m1_q, tcols_m1_d;
  size_t trows_m1_q, trows_m1_d;
  addr_t stride_c_q, stride_c_d;   // tile_base step when Tc advances
  addr_t stride_r_q, stride_r_d;   // row_base step when Tr advances
  addr_t rows_step_q, rows_step_d; // R, transpose column step
  sub_t  j_q, j_d;
  sub_t  i_q, i_d;
  size_t tc_q, tc_d;
  size_t tr_q, tr_d;
  addr_t lin_q, lin_d;
  addr_t row_base_q, row_base_d;
  addr_t tile_base_q, tile_base_d;
  addr_t trans_q, trans_d;

  logic  j_end, i_end, c_end;
  addr_t tiled;
  addr_t r_cur;

  assign j_end  = (j_q == '1);
  assign i_end  = (i_q == '1);
  assign c_end  = j_end && (tc_q == tcols_m1_q);
  assign last_o = c_end && i_end && (tr_q == trows_m1_q);

  // Within a tile the offset i*T+j is just the concatenation {i,j}; likewise
  // r = Tr*T+i is {Tr,i}.
  assign tiled = tile_base_q + addr_t'({i_q, j_q});
  assign r_cur = addr_t'({tr_q, i_q});

  always_comb begin
    src_addr_o = lin_q;
    dst_addr_o = tiled;
    unique case (mode_q)
      ROW_TILED: dst_addr_o = tiled;
      COL_TILED: dst_addr_o = tiled;
      UNTILE: begin
        src_addr_o = tiled;
        dst_addr_o = lin_q;
      end
      TRANSPOSE: dst_addr_o = trans_q;
      default: ;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    tcols_m1_d  = tcols_m1_q;
    trows_m1_d  = trows_m1_q;
    stride_c_d  = stride_c_q;
    stride_r_d  = stride_r_q;
    rows_step_d = rows_step_q;
    j_d         = j_q;
    i_d         = i_q;
    tc_d        = tc_q;
    tr_d        = tr_q;
    lin_d       = lin_q;
    row_base_d  = row_base_q;
    tile_base_d = tile_base_q;
    trans_d     = trans_q;

    if (load_i) begin
      mode_d      = mode_i;
      tcols_m1_d  = (cols_i >> TileLog2) - size_t'(1);
      trows_m1_d  = (rows_i >> TileLog2) - size_t'(1);
      rows_step_d = addr_t'(rows_i);
      // Row-major tile order steps T*T per tile column and C*T per tile row;
      // column-major tile order steps R*T per tile column and T*T per tile row.
      if (mode_i == COL_TILED) begin
        stride_c_d = addr_t'(rows_i) << TileLog2;
        stride_r_d = addr_t'(TileArea);
      end else begin
        stride_c_d = addr_t'(TileArea);
        stride_r_d = addr_t'(cols_i) << TileLog2;
      end
      j_d         = '0;
      i_d         = '0;
      tc_d        = '0;
      tr_d        = '0;
      lin_d       = '0;
      row_base_d  = '0;
      tile_base_d = '0;
      trans_d     = '0;
    end else if (adv_i) begin
      lin_d = lin_q + addr_t'(1);
      j_d   = j_q + sub_t'(1);
      if (!c_end) begin
        trans_d = trans_q + rows_step_q;
        if (j_end) begin
          tc_d        = tc_q + size_t'(1);
          tile_base_d = tile_base_q + stride_c_q;
        end
      end else begin
        tc_d    = '0;
        i_d     = i_q + sub_t'(1);
        trans_d = r_cur + addr_t'(1);
        if (i_end) begin
          tr_d        = tr_q + size_t'(1);
          row_base_d  = row_base_q + stride_r_q;
          tile_base_d = row_base_q + stride_r_q;
        end else begin
          tile_base_d = row_base_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q      <= ROW_TILED;
      tcols_m1_q  <= '0;
      trows_m1_q  <= '0;
      stride_c_q  <= '0;
      stride_r_q  <= '0;
      rows_step_q <= '0;
      j_q         <= '0;
      i_q         <= '0;
      tc_q        <= '0;
      tr_q        <= '0;
      lin_q       <= '0;
      row_base_q  <= '0;
      tile_base_q <= '0;
      trans_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      tcols_m1_q  <= tcols_m1_d;
      trows_m1_q  <= trows_m1_d;
      stride_c_q  <= stride_c_d;
      stride_r_q  <= stride_r_d;
      rows_step_q <= rows_step_d;
      j_q         <= j_d;
      i_q         <= i_d;
      tc_q        <= tc_d;
      tr_q        <= tr_d;
      lin_q       <= lin_d;
      row_base_q  <= row_base_d;
      tile_base_q <= tile_base_d;
      trans_q     <= trans_d;
    end
  end

endmodule

// File: rtl/remap_engine.sv
// Matrix remap engine: copies an R x C matrix from a source memory to a
// destination memory, one element per cycle, reordering it into row-tiled,
// column-tiled, untiled or transposed layout.
//   clk_i, rst_ni       : clock, async active-low reset
//   start_i             : job request (accepted only in IDLE)
//   mode_i, rows_i, cols_i : job parameters sampled at start
//   busy_o, done_o, err_o  : job status (done_o is a one-cycle pulse)
//   src_addr_o / src_rdata_i : source memory, read data one cycle after address
//   dst_addr_o / dst_wdata_o / dst_we_o : destination memory write port
module remap_engine
  import remap_pkg::*;
#(
  parameter int unsigned DataWidth     = 8,
  parameter int unsigned DataDepth     = 4096,
  parameter int unsigned AddrWidth     = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned TileSize      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic [SizeAddrWidth-1:0] rows_i,
  input  logic [SizeAddrWidth-1:0] cols_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [AddrWidth-1:0]     src_addr_o,
  input  logic [DataWidth-1:0]     src_rdata_i,
  output logic [AddrWidth-1:0]     dst_addr_o,
  output logic [DataWidth-1:0]     dst_wdata_o,
  output logic                     dst_we_o
);

  localparam int unsigned TileLog2  = $clog2(TileSize);
  localparam int unsigned ProdWidth = 2 * SizeAddrWidth;

  state_e               state_q, state_d;
  logic                 err_q, err_d;
  logic                 dst_we_q, dst_we_d;
  logic [AddrWidth-1:0] dst_addr_q, dst_addr_d;

  logic [ProdWidth-1:0] area;
  logic                 dims_ok;
  logic                 gen_load, gen_adv, gen_last;
  logic [AddrWidth-1:0] gen_src, gen_dst;

  assign area    = ProdWidth'(rows_i) * ProdWidth'(cols_i);
  assign dims_ok = (rows_i != '0) && (cols_i != '0) &&
                   (rows_i[TileLog2-1:0] == '0) && (cols_i[TileLog2-1:0] == '0) &&
                   (64'(area) <= 64'(DataDepth));

  remap_addr_gen #(
    .AddrWidth    (AddrWidth),
    .SizeAddrWidth(SizeAddrWidth),
    .TileSize     (TileSize)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (gen_load),
    .adv_i     (gen_adv),
    .mode_i    (mode_e'(mode_i)),
    .rows_i    (rows_i),
    .cols_i    (cols_i),
    .src_addr_o(gen_src),
    .dst_addr_o(gen_dst),
    .last_o    (gen_last)
  );

  // The element issued in RUN has its destination address and write enable
  // registered here; its data arrives from the source memory in the next
  // cycle and is forwarded straight to the write port.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    dst_we_d   = 1'b0;
    dst_addr_d = '0;
    gen_load   = 1'b0;
    gen_adv    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d    = !dims_ok;
          gen_load = dims_ok;
          state_d  = dims_ok ? RUN : DONE;
        end
      end
      RUN: begin
        gen_adv    = 1'b1;
        dst_we_d   = 1'b1;
        dst_addr_d = gen_dst;
        if (gen_last) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      dst_we_q   <= dst_we_d;
      dst_addr_q <= dst_addr_d;
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign src_addr_o  = (state_q == RUN) ? gen_src : '0;
  assign dst_addr_o  = dst_addr_q;
  assign dst_we_o    = dst_we_q;
  assign dst_wdata_o = dst_we_q ? src_rdata_i : '0;

endmodule

// File: tb/tb_remap_engine.sv
module tb_remap_engine;

  localparam int DW    = 8;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int SW    = 8;
  localparam int T     = 4;

  logic clk;
  logic rst_n;
  logic clr;

  int checks;
  int failures;

  logic [DW-1:0] src_mem [DEPTH];
  logic [DW-1:0] dst_mem [DEPTH];

  remap_engine_if #(.DataWidth(DW), .AddrWidth(AW), .SizeAddrWidth(SW)) bus ();

  remap_engine #(
    .DataWidth    (DW),
    .DataDepth    (DEPTH),
    .AddrWidth    (AW),
    .SizeAddrWidth(SW),
    .TileSize     (T)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (bus.start),
    .mode_i     (bus.mode),
    .rows_i     (bus.rows),
    .cols_i     (bus.cols),
    .busy_o     (bus.busy),
    .done_o     (bus.done),
    .err_o      (bus.err),
    .src_addr_o (bus.src_addr),
    .src_rdata_i(bus.src_rdata),
    .dst_addr_o (bus.dst_addr),
    .dst_wdata_o(bus.dst_wdata),
    .dst_we_o   (bus.dst_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read source memory, write-port destination memory.
  always @(posedge clk) bus.src_rdata <= src_mem[bus.src_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < DEPTH; a++) dst_mem[a] <= 8'hEE;
    end else if (bus.dst_we) begin
      dst_mem[bus.dst_addr] <= bus.dst_wdata;
    end
  end

  // Closed-form reference addresses.
  function automatic int ref_row_tiled(int R, int C, int r, int c);
    return ((r / T) * (C / T) + (c / T)) * T * T + (r % T) * T + (c % T);
  endfunction

  function automatic int ref_src(logic [1:0] m, int R, int C, int k);
    if (m == 2'd2) return ref_row_tiled(R, C, k / C, k % C);
    return k;
  endfunction

  function automatic int ref_dst(logic [1:0] m, int R, int C, int k);
    int r, c;
    r = k / C;
    c = k % C;
    case (m)
      2'd0:    return ref_row_tiled(R, C, r, c);
      2'd1:    return ((c / T) * (R / T) + (r / T)) * T * T + (r % T) * T + (c % T);
      2'd2:    return k;
      default: return c * R + r;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_dst();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Runs one job, checking per-cycle timing against the reference walk.
  task automatic run_job(input logic [1:0] m, input int r, input int c, input bit valid,
                         input bit scramble, output int done_cyc, output int writes,
                         output int bad, output int done_cnt, output bit err_at_done);
    int n;
    n = valid ? r * c : 0;
    done_cyc = -1;
    writes = 0;
    bad = 0;
    done_cnt = 0;
    err_at_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.rows  = SW'(r);
    bus.cols  = SW'(c);
    @(posedge clk);
    for (int cyc = 1; cyc <= n + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
      if (scramble && cyc == 3) begin
        bus.mode = ~m;
        bus.rows = SW'(10);
        bus.cols = SW'(3);
      end
      if (scramble && cyc == 5) bus.start = 1'b1;
      if (scramble && cyc == 6) bus.start = 1'b0;
      if (bus.dst_we) begin
        writes++;
        if (cyc >= 2 && cyc <= n + 1) begin
          if (bus.dst_addr != AW'(ref_dst(m, r, c, cyc - 2))) bad++;
          if (bus.dst_wdata != src_mem[ref_src(m, r, c, cyc - 2)]) bad++;
        end else begin
          bad++;
        end
      end
      if (cyc <= n && bus.src_addr != AW'(ref_src(m, r, c, cyc - 1))) bad++;
      if (bus.busy != (valid && cyc <= n + 1)) bad++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          err_at_done = bus.err;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_content(input string name, input logic [1:0] m, input int r, input int c);
    int bad;
    bad = 0;
    for (int k = 0; k < r * c; k++)
      if (dst_mem[ref_dst(m, r, c, k)] !== src_mem[ref_src(m, r, c, k)]) bad++;
    check(name, bad, 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int rows;
    int cols;
    bit err;
    int done_cyc;
    int writes;
    int pa0; int pv0;
    int pa1; int pv1;
    int pa2; int pv2;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, wr, bad, dn, cnt;
    bit ea;
    logic [DW-1:0] exp16 [16];

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.start = 1'b0;
    bus.mode = 2'd0;
    bus.rows = '0;
    bus.cols = '0;
    for (int k = 0; k < DEPTH; k++) src_mem[k] = DW'(k);

    vecs[0] = '{2'd0, 12, 8, 1'b0, 98, 96, 16, 4, 4, 8, 95, 95};
    vecs[1] = '{2'd1, 12, 8, 1'b0, 98, 96, 16, 32, 95, 95, 1, 1};
    vecs[2] = '{2'd3, 12, 8, 1'b0, 98, 96, 1, 8, 12, 1, 95, 95};
    vecs[3] = '{2'd0, 10, 8, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{2'd0, 0, 8, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{2'd1, 12, 6, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{2'd0, 64, 128, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{2'd0, 64, 64, 1'b0, 4098, 4096, 16, 4, 4, 64, 4095, 255};
    vecs[8] = '{2'd3, 4, 4, 1'b0, 18, 16, 1, 4, 4, 1, 15, 15};
    vecs[9] = '{2'd1, 4, 8, 1'b0, 34, 32, 16, 4, 4, 8, 31, 31};

    exp16 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd8, 8'd9, 8'd10, 8'd11,
              8'd16, 8'd17, 8'd18, 8'd19, 8'd24, 8'd25, 8'd26, 8'd27};

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.err, bus.dst_we, bus.src_addr,
                            bus.dst_addr, bus.dst_wdata}, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      clear_dst();
      run_job(vecs[v].mode, vecs[v].rows, vecs[v].cols, !vecs[v].err, !vecs[v].err,
              dc, wr, bad, dn, ea);
      check($sformatf("v%0d_done_cycle", v), dc, vecs[v].done_cyc);
      check($sformatf("v%0d_done_pulses", v), dn, 1);
      check($sformatf("v%0d_err", v), ea, vecs[v].err);
      check($sformatf("v%0d_writes", v), wr, vecs[v].writes);
      check($sformatf("v%0d_timing", v), bad, 0);
      if (!vecs[v].err) begin
        check_content($sformatf("v%0d_content", v), vecs[v].mode, vecs[v].rows, vecs[v].cols);
        check($sformatf("v%0d_probe0", v), dst_mem[vecs[v].pa0], vecs[v].pv0);
        check($sformatf("v%0d_probe1", v), dst_mem[vecs[v].pa1], vecs[v].pv1);
        check($sformatf("v%0d_probe2", v), dst_mem[vecs[v].pa2], vecs[v].pv2);
      end
    end

    // Row-tile into X, then untile X into Y.
    clear_dst();
    run_job(2'd0, 12, 8, 1'b1, 1'b0, dc, wr, bad, dn, ea);
    check("rt_done_cycle", dc, 98);
    bad = 0;
    for (int k = 0; k < 16; k++) if (dst_mem[k] !== exp16[k]) bad++;
    check("rt_first16", bad, 0);
    for (int k = 0; k < 96; k++) src_mem[k] = dst_mem[k];
    clear_dst();
    run_job(2'd2, 12, 8, 1'b1, 1'b1, dc, wr, bad, dn, ea);
    check("untile_done_cycle", dc, 98);
    check("untile_timing", bad, 0);
    bad = 0;
    for (int k = 0; k < 96; k++) if (dst_mem[k] !== DW'(k)) bad++;
    check("untile_identity", bad, 0);
    for (int k = 0; k < 96; k++) src_mem[k] = DW'(k);

    // err_o holds after a rejected job, then a valid start clears it.
    run_job(2'd0, 10, 8, 1'b0, 1'b0, dc, wr, bad, dn, ea);
    check("inv_err", ea, 1);
    repeat (3) @(negedge clk);
    check("err_hold", bus.err, 1);
    clear_dst();
    run_job(2'd0, 4, 4, 1'b1, 1'b1, dc, wr, bad, dn, ea);
    check("err_cleared", ea, 0);
    check("err_clear_job_done", dc, 18);

    // Reset in the middle of a 12x8 job.
    clear_dst();
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 2'd0;
    bus.rows = SW'(12);
    bus.cols = SW'(8);
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midjob_reset_outputs", {bus.busy, bus.done, bus.err, bus.dst_we, bus.src_addr,
                                   bus.dst_addr, bus.dst_wdata}, 0);
    wr = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (cyc == 3) rst_n = 1'b1;
      if (bus.dst_we) wr++;
    end
    check("post_reset_writes", wr, 0);
    check("post_reset_busy", bus.busy, 0);
    cnt = 0;
    for (int k = 0; k < DEPTH; k++) if (dst_mem[k] !== 8'hEE) cnt++;
    check("aborted_job_words", cnt, 38);
    clear_dst();
    run_job(2'd0, 12, 8, 1'b1, 1'b0, dc, wr, bad, dn, ea);
    check("after_reset_done_cycle", dc, 98);
    check("after_reset_writes", wr, 96);
    check("after_reset_timing", bad, 0);
    check_content("after_reset_content", 2'd0, 12, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
